// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbitrated output mux.
package rr_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Select width never drops below one bit, even for degenerate channel counts
    function automatic int sel_w(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority grant generator. Owns the priority pointer,
// which only moves when the grant is actually taken (advance).
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [SEL_W-1:0] ptr;
    logic             found;

    // Cyclic search: first pass covers ptr..CHANNELS-1, second pass wraps to 0..ptr-1
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i] && (ARB_MODE == ARB_FIXED || i >= int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

    // Pointer moves past the winner on acceptance; explicit wrap handles non-power-of-two counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && ARB_MODE == ARB_RR) begin
            ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-way selector: arbitrates CHANNELS valid/ready requesters into a
// single-entry output register.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | output register holds nothing, out_valid=0
// ST_FULL  | output register holds a beat, out_valid=1
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req_valid,
    input  logic [CHANNELS*WIDTH-1:0] req_data,
    output logic [CHANNELS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    out_state_t          state;
    out_state_t          state_nxt;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                can_accept;
    logic                accept;
    logic [WIDTH-1:0]    mux_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: a slot frees up if the register is empty or being drained this cycle.
    // Reset gating keeps req_ready low while reset is held even though the register looks empty.
    always_comb begin
        can_accept = (state == ST_EMPTY) || out_ready;
        req_ready  = reset ? '0 : (grant & {CHANNELS{can_accept}});
        accept     = |req_ready;
        mux_data   = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fill on acceptance, empty only on a drain without a refill
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        out_valid = (state == ST_FULL);
    end

    // Payload and source index load on acceptance, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (accept) begin
            out_data <= mux_data;
            out_sel  <= grant_idx;
        end
    end

endmodule
